// File: rtl/encoder_pkg.sv
// encoder_pkg
//   Shared widths and types for the registered one-hot to binary encoder.
//   ENC_IN_W  : default request vector width (power of two, >= 2)
//   ENC_OUT_W : matching binary index width, $clog2(ENC_IN_W)
package encoder_pkg;

  localparam int unsigned ENC_IN_W  = 8;
  localparam int unsigned ENC_OUT_W = $clog2(ENC_IN_W);

  typedef logic [ENC_IN_W-1:0]  enc_onehot_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : encoder_pkg

// File: rtl/encoder_core.sv
// encoder_core
//   Combinational MSB-priority encoder with status flags.
//   Ports:
//     in    [IN_W-1:0]  request vector (nominally one-hot)
//     idx   [OUT_W-1:0] index of the highest set bit, 0 when in == 0
//     any               at least one bit of in is set
//     multi             two or more bits of in are set
module encoder_core
  import encoder_pkg::*;
#(
  parameter int unsigned IN_W  = ENC_IN_W,
  parameter int unsigned OUT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (in[i]) begin
        idx = OUT_W'(i);
      end
    end
  end

  assign any = |in;

  // A set bit with another set bit below it means the vector is not one-hot.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      multi = multi | (seen & in[i]);
      seen  = seen | in[i];
    end
  end

endmodule : encoder_core

// File: rtl/encoder.sv
// encoder
//   Registered 8-to-3 (generic IN_W) priority encoder. Result of the input
//   sampled at a rising edge is presented after that edge; all outputs update
//   together. Asynchronous active-low reset clears all outputs immediately.
//   Ports:
//     clk            rising-edge clock
//     rst_n          asynchronous reset, active low
//     in    [IN_W-1:0]  request vector, sampled every cycle
//     out   [OUT_W-1:0] registered index of the highest set bit
//     valid          registered: sampled in had any bit set
//     multi          registered: sampled in had two or more bits set
module encoder
  import encoder_pkg::*;
#(
  parameter int unsigned IN_W  = ENC_IN_W,
  parameter int unsigned OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic             multi
);

  logic [OUT_W-1:0] out_d,   out_q;
  logic             valid_d, valid_q;
  logic             multi_d, multi_q;

  encoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in    (in),
    .idx   (out_d),
    .any   (valid_d),
    .multi (multi_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule : encoder

// File: tb/tb_encoder.sv
module tb_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [2:0] dout;
  logic       dvalid;
  logic       dmulti;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] stim;
    logic [2:0] out;
    logic       valid;
    logic       multi;
  } exp_t;

  exp_t sb[$];

  encoder #(.IN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (din),
    .out   (dout),
    .valid (dvalid),
    .multi (dmulti)
  );

  always #5 clk = ~clk;

  // Reference: top-down search for the first set bit.
  function automatic exp_t model(input logic [7:0] v);
    exp_t e;
    e.stim  = v;
    e.out   = 3'd0;
    e.valid = (v != 8'h00);
    e.multi = ($countones(v) >= 2);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        e.out = 3'(i);
        break;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"},   {5'd0, dout},   8'd0);
    check({tag, ".valid"}, {7'd0, dvalid}, 8'd0);
    check({tag, ".multi"}, {7'd0, dmulti}, 8'd0);
  endtask

  // Pop one expectation and compare against the registered outputs.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".out"},   {5'd0, dout},   {5'd0, e.out});
      check({tag, ".valid"}, {7'd0, dvalid}, {7'd0, e.valid});
      check({tag, ".multi"}, {7'd0, dmulti}, {7'd0, e.multi});
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [7:0] v, input string tag);
    @(negedge clk);
    din = v;
    sb.push_back(model(v));
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    din   = 8'h00;
    #2;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(8'h01 << i, $sformatf("walk%0d", i));
    end

    step(8'h00, "zero");
    step(8'h01, "bit0");

    step(8'h12, "multi_12");
    step(8'hFF, "multi_FF");
    step(8'h81, "multi_81");

    // Async reset between edges while out == 5; pending result discarded.
    step(8'h20, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_midcycle");
    @(posedge clk);
    #1;
    check_zero("rst_over_edge");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    din = 8'h08;
    sb.push_back(model(8'h08));
    @(posedge clk);
    #1;
    pop_check("post_reset");
    check("post_reset.const", {5'd0, dout}, 8'd3);

    // Mid-cycle input change is invisible until the next edge.
    step(8'h04, "latency_a");
    #2;
    din = 8'h40;
    #1;
    check("hold_midcycle", {5'd0, dout}, 8'd2);
    sb.push_back(model(8'h40));
    @(posedge clk);
    #1;
    pop_check("latency_b");

    step(8'h40, "hold1");
    step(8'h40, "hold2");

    // Back-to-back random stimulus against the model.
    for (int i = 0; i < 20; i++) begin
      step(8'($urandom_range(0, 255)), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_encoder
